axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI/command address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width (only 32 supported).
REQ-003 SHALL have parameter C_TIMEOUT_CYCLES, default 1024, response-wait limit in cycles; 0 disables timeout.
REQ-004 m_axi_aclk  input  1  sole clock, all logic on rising edge.
REQ-005 m_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd_we  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  C_M_AXI_ADDR_WIDTH  target byte address.
REQ-010 cmd_wdata  input  32  write data.
REQ-011 cmd_wstrb  input  4  write byte strobes.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-015 rsp_resp  output  2  AXI BRESP/RRESP; 2'b11 on timeout.
REQ-016 m_axi_awaddr  output  C_M_AXI_ADDR_WIDTH  write address.
REQ-017 m_axi_awvalid  output  1  write address valid.
REQ-018 m_axi_awready  input  1  write address ready.
REQ-019 m_axi_wdata  output  32  write data.
REQ-020 m_axi_wstrb  output  4  write strobes.
REQ-021 m_axi_wvalid  output  1  write data valid.
REQ-022 m_axi_wready  input  1  write data ready.
REQ-023 m_axi_bresp  input  2  write response code.
REQ-024 m_axi_bvalid  input  1  write response valid.
REQ-025 m_axi_bready  output  1  write response ready.
REQ-026 m_axi_araddr  output  C_M_AXI_ADDR_WIDTH  read address.
REQ-027 m_axi_arvalid  output  1  read address valid.
REQ-028 m_axi_arready  input  1  read address ready.
REQ-029 m_axi_rdata  input  32  read data.
REQ-030 m_axi_rresp  input  2  read response code.
REQ-031 m_axi_rvalid  input  1  read data valid.
REQ-032 m_axi_rready  output  1  read data ready.

Function
REQ-033 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ_A, WAIT_R, RSP, DRAIN; one transaction outstanding at a time.
REQ-034 cmd_ready SHALL equal (state==IDLE); on handshake, addr/wdata/wstrb register and FSM enters WRITE (cmd_we=1) or READ_A (cmd_we=0).
REQ-035 WRITE: awvalid and wvalid assert from the first cycle, each deasserting independently the cycle after its own handshake; addr/data stable while valid; FSM enters WAIT_B once both handshakes complete, including same-cycle completion.
REQ-036 READ_A: arvalid held with stable araddr until arready; then WAIT_R.
REQ-037 bready SHALL be high only in WAIT_B or write-DRAIN; rready only in WAIT_R or read-DRAIN.
REQ-038 WAIT_B/WAIT_R: on bvalid/rvalid, capture resp (and rdata for reads) and enter RSP; response latency with zero-wait slave: cmd handshake cycle N, AXI address at N+1, rsp_valid at N+3.
REQ-039 Timeout counter SHALL clear on entry to WAIT_B/WAIT_R, increment each waiting cycle, and on reaching C_TIMEOUT_CYCLES without handshake enter RSP with rsp_resp=2'b11, rsp_rdata=0, drain flag set; no timeout in WRITE/READ_A (valids never withdrawn).
REQ-040 RSP: rsp_valid high with outputs stable until rsp_ready; then DRAIN if drain flag set, else IDLE.
REQ-041 DRAIN: cmd_ready=0; late bvalid/rvalid accepted and discarded, then IDLE.
REQ-042 Response arriving same cycle timeout expires SHALL win (normal completion, no drain).

Reset
REQ-043 While m_axi_aresetn low: state=IDLE, all valid/ready outputs 0, rsp_rdata=0, rsp_resp=0, counter=0, drain flag=0; mid-transaction reset abandons it with no response.

Verification
REQ-044 Write 0x0000_0004 data 0x0000_00FF strb 0xF to zero-wait slave -> aw/w handshake N+1, bready N+2, rsp_valid N+3 rsp_resp=00.
REQ-045 Read 0x0000_0120 with slave rdata 0x0000_0003 -> rsp_rdata=0x0000_0003, rsp_resp=00 at N+3.
REQ-046 wready delayed 5 cycles after awready -> awvalid drops after its handshake, wvalid held 5 cycles, one bready handshake, single response.
REQ-047 C_TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> rsp_resp=11 after 8 WAIT_B cycles; DRAIN absorbs late bvalid; cmd_ready 0 until then.
REQ-048 rsp_ready held low 4 cycles -> rsp_valid/rsp_rdata stable; reset asserted during WAIT_R -> all valids 0 immediately, IDLE after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: a simple command/response port is
// translated into one AXI-Lite read or write, with a response-wait timeout.
module axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  // command / response port
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  // debug
  output logic [2:0]                      dbg_state_o
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; a valid, once raised, is held with stable payload until then.

  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int CW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (C_TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_B, S_READ_A, S_WAIT_R, S_RSP, S_DRAIN
  } state_e;

  state_e                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]                 wstrb_q, wstrb_d;
  logic                          we_q, we_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    resp_q, resp_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          drain_q, drain_d;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;

    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // gated so every ready/valid output reads 0 while reset is held
        cmd_ready = m_axi_aresetn;
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          we_d      = cmd_we;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we ? S_WRITE : S_READ_A;
        end
      end
      S_WRITE: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        aw_done_d     = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d      = w_done_q  | (m_axi_wvalid  & m_axi_wready);
        if (aw_done_d && w_done_d) begin
          cnt_d   = '0;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        m_axi_bready = 1'b1;
        // a response in the expiry cycle still completes normally
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          resp_d  = 2'b11;
          rdata_d = '0;
          drain_d = 1'b1;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ_A: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          cnt_d   = '0;
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          resp_d  = m_axi_rresp;
          rdata_d = m_axi_rdata;
          state_d = S_RSP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          resp_d  = 2'b11;
          rdata_d = '0;
          drain_d = 1'b1;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = drain_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        // swallow the late response of a timed-out transaction
        m_axi_bready = we_q;
        m_axi_rready = !we_q;
        if ((we_q && m_axi_bvalid) || (!we_q && m_axi_rvalid)) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI-Lite slave plus a
// transaction-level model predicting response value and latency.
module tb_axi_lite_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [2:0]  dbg_state;

  axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- slave model ----------------
  int cfg_aw, cfg_w, cfg_ar, cfg_d;
  logic [1:0]  cfg_resp;
  logic [31:0] cfg_rdata, cur_addr, cur_wdata;
  logic [3:0]  cur_strb;
  bit aw_pend, w_pend, ar_pend, b_pend, r_pend, aw_done, w_done, ar_done;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  int aw_cyc, b_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      // retire handshakes that happened on the rising edge just passed
      if (aw_pend) begin aw_pend = 0; awready = 0; aw_done = 1; aw_cnt = 0; aw_n++; chk("awvalid_drop", 32'(awvalid), 0); end
      if (w_pend)  begin w_pend = 0;  wready = 0;  w_done = 1;  w_cnt = 0;  w_n++;  chk("wvalid_drop", 32'(wvalid), 0); end
      if (ar_pend) begin ar_pend = 0; arready = 0; ar_done = 1; ar_cnt = 0; ar_n++; chk("arvalid_drop", 32'(arvalid), 0); end
      if (b_pend)  begin b_pend = 0;  bvalid = 0;  aw_done = 0; w_done = 0; b_cnt = 0; b_n++; end
      if (r_pend)  begin r_pend = 0;  rvalid = 0;  rdata = 0; ar_done = 0; r_cnt = 0; r_n++; end
      if (!w_done && w_cnt > 0) chk("wvalid_hold", 32'(wvalid), 1);
      if (awvalid) chk("awaddr", awaddr, cur_addr);
      if (wvalid) begin chk("wdata", wdata, cur_wdata); chk("wstrb", 32'(wstrb), 32'(cur_strb)); end
      if (arvalid) chk("araddr", araddr, cur_addr);
      if (awvalid && !aw_done && !awready) begin
        if (aw_cnt >= cfg_aw) begin awready = 1; aw_cyc = cyc; end else aw_cnt++;
      end
      if (wvalid && !w_done && !wready) begin
        if (w_cnt >= cfg_w) wready = 1; else w_cnt++;
      end
      if (arvalid && !ar_done && !arready) begin
        if (ar_cnt >= cfg_ar) arready = 1; else ar_cnt++;
      end
      if (aw_done && w_done && !bvalid) begin
        if (b_cnt >= cfg_d) begin bvalid = 1; bresp = cfg_resp; end else b_cnt++;
      end
      if (ar_done && !rvalid) begin
        if (r_cnt >= cfg_d) begin rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata; end else r_cnt++;
      end
      if (awvalid && awready) aw_pend = 1;
      if (wvalid && wready) w_pend = 1;
      if (arvalid && arready) ar_pend = 1;
      if (bvalid && bready) begin b_pend = 1; b_cyc = cyc; end
      if (rvalid && rready) r_pend = 1;
    end
  end

  // ---------------- driver + reference model ----------------
  logic [33:0] exp_q[$];
  int last_n;

  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int aw_d, input int w_d, input int ar_d,
                        input int d, input logic [1:0] resp, input logic [31:0] rd, input int stall);
    bit to;
    int exp_lat, lat, t, hs0, aw0, w0, ar0;
    logic [33:0] e;
    cfg_aw = aw_d; cfg_w = w_d; cfg_ar = ar_d; cfg_d = d; cfg_resp = resp; cfg_rdata = rd;
    cur_addr = addr; cur_wdata = wd; cur_strb = strb;
    // model: timeout iff no response within TO waiting cycles
    to = (d >= TO);
    exp_q.push_back({(to ? 2'b11 : resp), ((we || to) ? 32'h0 : rd)});
    exp_lat = 1 + (we ? ((aw_d > w_d) ? aw_d : w_d) : ar_d) + 1 + (to ? TO : d + 1);
    hs0 = we ? b_n : r_n; aw0 = aw_n; w0 = w_n; ar0 = ar_n;

    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    t = 0;
    while (!cmd_ready && t < 200) begin tick(); t++; end
    chk("cmd_accept_bound", 32'(t < 200), 1);
    last_n = cyc;
    tick();
    cmd_valid = 0; cmd_we = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

    t = 0;
    while (!rsp_valid && t < 300) begin tick(); t++; end
    chk("rsp_bound", 32'(t < 300), 1);
    lat = cyc - last_n;
    chk("latency", lat, exp_lat);
    e = exp_q.pop_front();
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_rdata", rsp_rdata, e[31:0]);
      chk("stall_resp", 32'(rsp_resp), 32'(e[33:32]));
      tick();
    end
    rsp_ready = 1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", rsp_rdata, e[31:0]);
    chk("rsp_resp", 32'(rsp_resp), 32'(e[33:32]));
    tick();
    rsp_ready = 0;
    chk("rsp_single", 32'(rsp_valid), 0);

    t = 0;
    while (((we ? b_n : r_n) == hs0) && t < 100) begin
      chk("drain_cmd_ready", 32'(cmd_ready), 0);
      tick(); t++;
    end
    chk("drain_bound", 32'(t < 100), 1);
    chk("resp_hs_count", (we ? b_n : r_n) - hs0, 1);
    if (we) begin
      chk("aw_hs_count", aw_n - aw0, 1);
      chk("w_hs_count", w_n - w0, 1);
    end else begin
      chk("ar_hs_count", ar_n - ar0, 1);
    end
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_awvalid"}, 32'(awvalid), 0);
    chk({tag, "_wvalid"}, 32'(wvalid), 0);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_bready"}, 32'(bready), 0);
    chk({tag, "_rready"}, 32'(rready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, 32'(rsp_resp), 0);
  endtask

  initial begin
    int t, seen;
    rst_n = 0;
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_d = 0; cfg_resp = 0; cfg_rdata = 0;
    cur_addr = 0; cur_wdata = 0; cur_strb = 0;
    tick(); tick();
    chk_quiet("reset");
    rst_n = 1;
    tick();
    chk("post_reset_cmd_ready", 32'(cmd_ready), 1);

    // zero-wait write and read
    do_txn(1, 32'h0000_0004, 32'h0000_00FF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("wr_aw_hs_cycle", aw_cyc - last_n, 1);
    chk("wr_b_hs_cycle", b_cyc - last_n, 2);
    do_txn(0, 32'h0000_0120, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h0000_0003, 0);
    // wready five cycles behind awready
    do_txn(1, 32'h0000_0040, 32'hA5A5_1234, 4'h5, 0, 5, 0, 0, 2'b01, 32'h0, 0);
    // write timeout with late response drained
    do_txn(1, 32'h0000_0080, 32'hDEAD_BEEF, 4'hC, 0, 0, 0, 20, 2'b00, 32'h0, 0);
    // response in the last allowed cycle wins; one cycle later times out
    do_txn(1, 32'h0000_0100, 32'h1111_2222, 4'h3, 1, 0, 0, TO - 1, 2'b10, 32'h0, 0);
    do_txn(0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 2, TO - 1, 2'b00, 32'h7777_0001, 0);
    do_txn(0, 32'h0000_0204, 32'h0, 4'h0, 0, 0, 0, TO, 2'b00, 32'h7777_0002, 1);
    // response held four cycles
    do_txn(0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 1, 2, 2'b01, 32'hCAFE_F00D, 4);

    for (int i = 0; i < 40; i++) begin
      do_txn($urandom_range(0, 1), {$urandom_range(0, 16'hFFFF), 2'b00} , $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, TO + 2), 2'($urandom), $urandom, $urandom_range(0, 3));
    end

    // reset in the middle of a read response wait
    cfg_ar = 0; cfg_d = 30; cfg_resp = 0; cfg_rdata = 32'h1234_5678; cur_addr = 32'h0000_0400;
    seen = ar_n;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h0000_0400;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    tick();
    cmd_valid = 0;
    t = 0;
    while (ar_n == seen && t < 50) begin tick(); t++; end
    chk("midrst_ar_bound", 32'(t < 50), 1);
    tick(); tick();
    chk("midrst_waiting", 32'(rready), 1);
    rst_n = 0;
    #1;
    chk_quiet("midrst");
    tick(); tick();
    rst_n = 1;
    tick();
    chk("midrst_cmd_ready", 32'(cmd_ready), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("midrst_no_rsp", seen, 0);
    do_txn(1, 32'h0000_0500, 32'h0BAD_F00D, 4'hF, 2, 1, 0, 1, 2'b00, 32'h0, 1);
    do_txn(0, 32'h0000_0504, 32'h0, 4'h0, 0, 0, 0, 0, 2'b11, 32'h5555_AAAA, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
